alu_74181_nibble_seq: RTL and testbench

Sequencer that sits directly upstream and downstream of the 74181 logic stage. It collects operand A, operand B and function select S as 4-bit nibbles over a valid/ready input stream and drives them to the logic stage. It then registers the stage's combinational result and presents it on a valid/ready output stream. A chain mode reuses the previous result as operand A, so multi-step logic expressions need no re-sending of intermediate values.

---
 rtl/alu_74181_pkg.sv | 32 +++
 rtl/alu_74181_nibble_seq.sv | 158 +++++++++++++++
 tb/tb_alu_74181_nibble_seq.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_74181_pkg.sv
// alu_74181_pkg
// Definitions shared by the nibble sequencer and the 74181 logic stage:
//   seq_state_t      - sequencer FSM state encoding
//   FUNC_00..FUNC_15 - 4-bit logic-stage function select codes
package alu_74181_pkg;

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_S    = 3'd2,
    ST_EXEC = 3'd3,
    ST_OUT  = 3'd4
  } seq_state_t;

  localparam logic [3:0] FUNC_00 = 4'd0;   // ~A
  localparam logic [3:0] FUNC_01 = 4'd1;   // ~(A|B)
  localparam logic [3:0] FUNC_02 = 4'd2;   // ~A&B
  localparam logic [3:0] FUNC_03 = 4'd3;   // 0000
  localparam logic [3:0] FUNC_04 = 4'd4;   // ~(A&B)
  localparam logic [3:0] FUNC_05 = 4'd5;   // ~B
  localparam logic [3:0] FUNC_06 = 4'd6;   // A^B
  localparam logic [3:0] FUNC_07 = 4'd7;   // A&~B
  localparam logic [3:0] FUNC_08 = 4'd8;   // ~A|B
  localparam logic [3:0] FUNC_09 = 4'd9;   // ~(A^B)
  localparam logic [3:0] FUNC_10 = 4'd10;  // B
  localparam logic [3:0] FUNC_11 = 4'd11;  // A&B
  localparam logic [3:0] FUNC_12 = 4'd12;  // 1111
  localparam logic [3:0] FUNC_13 = 4'd13;  // A|~B
  localparam logic [3:0] FUNC_14 = 4'd14;  // A|B
  localparam logic [3:0] FUNC_15 = 4'd15;  // A

endpackage

// File: rtl/alu_74181_nibble_seq.sv
// alu_74181_nibble_seq
// Collects operand A, operand B and select S as nibbles over a valid/ready
// stream, holds them registered for the external 74181 logic stage, captures
// the stage result and offers it on a valid/ready output stream. Chain mode
// reuses the previous result as A.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_nibble/in_valid/in_ready input nibble stream
//   chain                       reuse previous result as A (sampled in ST_A)
//   clear                       synchronous abort of the current transaction
//   lu_a/lu_b/lu_s              registered operands/select to the logic stage
//   lu_f                        combinational result from the logic stage
//   out_f/out_valid/out_ready   result stream
//   busy                        high whenever not in ST_A
//   op_count                    completed output handshakes (wrapping)
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_A    | idle; take A nibble, or copy out_f into A when chaining
// ST_B    | wait for B nibble
// ST_S    | wait for S nibble
// ST_EXEC | logic stage inputs stable; capture lu_f into out_f
// ST_OUT  | present out_f until downstream accepts it
module alu_74181_nibble_seq
  import alu_74181_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_nibble,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             chain,
  input  logic             clear,
  output logic [3:0]       lu_a,
  output logic [3:0]       lu_b,
  output logic [3:0]       lu_s,
  input  logic [3:0]       lu_f,
  output logic [3:0]       out_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  seq_state_t       state_q, state_d;
  logic [3:0]       lu_a_q, lu_a_d;
  logic [3:0]       lu_b_q, lu_b_d;
  logic [3:0]       lu_s_q, lu_s_d;
  logic [3:0]       out_f_q, out_f_d;
  logic             out_valid_q, out_valid_d;
  logic             prev_valid_q, prev_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             chain_skip;

  // Chaining only makes sense once a result exists; otherwise chain is ignored.
  assign chain_skip = chain && prev_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_A;
      lu_a_q       <= '0;
      lu_b_q       <= '0;
      lu_s_q       <= '0;
      out_f_q      <= '0;
      out_valid_q  <= 1'b0;
      prev_valid_q <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      lu_a_q       <= lu_a_d;
      lu_b_q       <= lu_b_d;
      lu_s_q       <= lu_s_d;
      out_f_q      <= out_f_d;
      out_valid_q  <= out_valid_d;
      prev_valid_q <= prev_valid_d;
      op_count_q   <= op_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lu_a_d       = lu_a_q;
    lu_b_d       = lu_b_q;
    lu_s_d       = lu_s_q;
    out_f_d      = out_f_q;
    out_valid_d  = out_valid_q;
    prev_valid_d = prev_valid_q;
    op_count_d   = op_count_q;
    in_ready     = 1'b0;

    unique case (state_q)
      ST_A: begin
        in_ready = !chain_skip;
        if (chain_skip) begin
          lu_a_d  = out_f_q;
          state_d = ST_B;
        end else if (in_valid) begin
          lu_a_d  = in_nibble;
          state_d = ST_B;
        end
      end
      ST_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lu_b_d  = in_nibble;
          state_d = ST_S;
        end
      end
      ST_S: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lu_s_d  = in_nibble;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        out_f_d      = lu_f;
        out_valid_d  = 1'b1;
        prev_valid_d = 1'b1;
        state_d      = ST_OUT;
      end
      ST_OUT: begin
        // out_valid is always high here, so out_ready alone completes the transfer.
        if (out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = ST_A;
        end
      end
      default: state_d = ST_A;
    endcase

    // Abort wins over any handshake in the same cycle; operand and result
    // registers keep their previous contents.
    if (clear) begin
      state_d      = ST_A;
      lu_a_d       = lu_a_q;
      lu_b_d       = lu_b_q;
      lu_s_d       = lu_s_q;
      out_f_d      = out_f_q;
      out_valid_d  = 1'b0;
      prev_valid_d = 1'b0;
      op_count_d   = op_count_q;
    end
  end

  assign lu_a      = lu_a_q;
  assign lu_b      = lu_b_q;
  assign lu_s      = lu_s_q;
  assign out_f     = out_f_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_A);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_74181_nibble_seq.sv
module tb_alu_74181_nibble_seq;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [3:0]       in_nibble;
  logic             in_valid;
  logic             in_ready;
  logic             chain;
  logic             clear;
  logic [3:0]       lu_a, lu_b, lu_s, lu_f;
  logic [3:0]       out_f;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  logic             drv_oready;
  logic             rand_oready;
  logic             rnd_bit;

  int               checks;
  int               errors;
  logic [3:0]       exp_q[$];
  logic [CNT_W-1:0] exp_cnt;

  // Driver-side reference state: the last result and whether chaining is legal.
  logic [3:0]       prev_res;
  bit               pv;

  alu_74181_nibble_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_nibble (in_nibble),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .chain     (chain),
    .clear     (clear),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_s      (lu_s),
    .lu_f      (lu_f),
    .out_f     (out_f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] s);
    case (s)
      4'd0:    return ~a;
      4'd1:    return ~(a | b);
      4'd2:    return ~a & b;
      4'd3:    return 4'h0;
      4'd4:    return ~(a & b);
      4'd5:    return ~b;
      4'd6:    return a ^ b;
      4'd7:    return a & ~b;
      4'd8:    return ~a | b;
      4'd9:    return ~(a ^ b);
      4'd10:   return b;
      4'd11:   return a & b;
      4'd12:   return 4'hF;
      4'd13:   return a | ~b;
      4'd14:   return a | b;
      default: return a;
    endcase
  endfunction

  // Behavioural logic stage feeding the sequencer.
  assign lu_f = ref_f(lu_a, lu_b, lu_s);

  always @(posedge clk) begin
    #1 rnd_bit = ($urandom_range(0, 3) != 0);
  end
  assign out_ready = rand_oready ? rnd_bit : drv_oready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      chk("op_count", 32'(op_count), 32'(exp_cnt));
      if (out_valid) begin
        chk("in_ready_in_out", 32'(in_ready), 32'd0);
        chk("busy_in_out", 32'(busy), 32'd1);
      end
      if (out_valid && out_ready && !clear) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%0h expected none at %0t", out_f, $time);
        end else begin
          chk("out_f", 32'(out_f), 32'(exp_q.pop_front()));
        end
        exp_cnt = exp_cnt + 1'b1;
      end
    end
  end

  task automatic send(input logic [3:0] n);
    int t;
    in_nibble = n;
    in_valid  = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 400) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
        finish_sim();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                         input bit ch);
    logic [3:0] av;
    chain = ch;
    if (ch && pv) begin
      av = prev_res;
      send(b);
      chain = 1'b0;
      send(s);
    end else begin
      av = a;
      send(a);
      chain = 1'b0;
      send(b);
      send(s);
    end
    in_valid = 1'b0;
    exp_q.push_back(ref_f(av, b, s));
    prev_res = ref_f(av, b, s);
    pv = 1'b1;
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      t++;
      if (t > 50) begin
        checks++;
        errors++;
        $display("FAIL out_valid_timeout: got 0 expected 1 at %0t", $time);
        finish_sim();
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 || busy) begin
      @(negedge clk);
      t++;
      if (t > 500) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0 at %0t", exp_q.size(), $time);
        finish_sim();
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; exp_cnt = '0;
    pv = 1'b0; prev_res = '0;
    rst_n = 1'b0; in_nibble = '0; in_valid = 1'b0; chain = 1'b0; clear = 1'b0;
    drv_oready = 1'b1; rand_oready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_f", 32'(out_f), 32'd0);
    chk("rst_lu", {20'd0, lu_a, lu_b, lu_s}, 32'd0);
    @(posedge clk); #1;

    // Basic transaction with latency check: A^C = 6
    run_txn(4'hA, 4'hC, 4'd6, 1'b0);
    @(negedge clk);
    chk("exec_out_valid", 32'(out_valid), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("one_cycle_valid", 32'(out_valid), 32'd0);
    drain();

    // Back-to-back: 0x8 then 0xA
    run_txn(4'hA, 4'hC, 4'd11, 1'b0);
    run_txn(4'h5, 4'h0, 4'd1, 1'b0);
    drain();

    // Chain: 6 | 3 = 7
    run_txn(4'hA, 4'hC, 4'd6, 1'b0);
    run_txn(4'h0, 4'h3, 4'd14, 1'b1);
    drain();
    chk("chain_lu_a", 32'(lu_a), 32'h6);

    // Clear after A and B, then chain requested while prev_valid=0
    send(4'h1);
    send(4'h2);
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    pv = 1'b0;
    @(negedge clk);
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    run_txn(4'h9, 4'h3, 4'd6, 1'b1);
    drain();
    chk("fresh_lu_a", 32'(lu_a), 32'h9);

    // Backpressure for 5 cycles
    drv_oready = 1'b0;
    run_txn(4'h3, 4'h5, 4'd7, 1'b0);
    wait_out_valid();
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_f", 32'(out_f), 32'h2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    drv_oready = 1'b1;
    drain();

    // Clear coinciding with an output handshake
    drv_oready = 1'b0;
    run_txn(4'hF, 4'h1, 4'd9, 1'b0);
    wait_out_valid();
    @(posedge clk); #1;
    drv_oready = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    void'(exp_q.pop_back());
    pv = 1'b0;
    @(negedge clk);
    chk("clrhs_out_valid", 32'(out_valid), 32'd0);
    chk("clrhs_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Reset asserted in ST_EXEC
    run_txn(4'h7, 4'h7, 4'd14, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rexec_out_valid", 32'(out_valid), 32'd0);
    chk("rexec_busy", 32'(busy), 32'd0);
    chk("rexec_out_f", 32'(out_f), 32'd0);
    chk("rexec_op_count", 32'(op_count), 32'd0);
    chk("rexec_lu", {20'd0, lu_a, lu_b, lu_s}, 32'd0);
    pv = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 256 randomized transactions with random backpressure: counter wraps to 0
    rand_oready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      run_txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end
    drain();
    rand_oready = 1'b0;
    @(negedge clk);
    chk("wrap_op_count", 32'(op_count), 32'd0);

    finish_sim();
  end

endmodule
